// File: rtl/led_panel_if.sv
// Bundles the mode/pattern inputs and LED/status outputs of led_panel_ctrl.
// master drives the pattern inputs; slave is the controller side.
interface led_panel_if #(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned PWM_BITS = 4
);
    logic [2:0]          mode;
    logic [N_LED-1:0]    score;
    logic                right;
    logic [N_LED+1:0]    track;
    logic [3:0]          blink_n;
    logic [PWM_BITS-1:0] bright;
    logic [N_LED-1:0]    led;
    logic                blink_done;
    logic                busy;

    modport master (
        output mode, score, right, track, blink_n, bright,
        input  led, blink_done, busy
    );

    modport slave (
        input  mode, score, right, track, blink_n, bright,
        output led, blink_done, busy
    );
endinterface

// File: rtl/led_panel_ctrl.sv
// LED panel controller: OFF/SCORE/SERVE/TRACK/BLINK/CHASE display modes, active-low reversed drive.
// Optional brightness PWM gating is enabled by defining LED_PWM_EN.
module led_panel_ctrl #(
    parameter int unsigned N_LED     = 4,
    parameter int unsigned BLINK_CYC = 25000000,
    parameter int unsigned PWM_BITS  = 4
) (
    input logic         clk,
    input logic         rst,
    led_panel_if.slave  bus
);
    localparam int unsigned PhW = $clog2(BLINK_CYC);
    localparam int unsigned PosW = $clog2(N_LED);
    localparam logic [PhW-1:0]  PhaseMax = PhW'(BLINK_CYC - 1);
    localparam logic [PosW-1:0] PosMax   = PosW'(N_LED - 1);

    localparam logic [2:0] ModeOff   = 3'd0;
    localparam logic [2:0] ModeScore = 3'd1;
    localparam logic [2:0] ModeServe = 3'd2;
    localparam logic [2:0] ModeTrack = 3'd3;
    localparam logic [2:0] ModeBlink = 3'd4;
    localparam logic [2:0] ModeChase = 3'd5;

    typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} blink_st_e;

    blink_st_e        st_q, st_d;
    logic [2:0]       mode_q;
    logic [PhW-1:0]   phase_q, phase_d;
    logic [PosW-1:0]  pos_q, pos_d;
    logic [3:0]       per_q, per_d, per_inc;
    logic [3:0]       n_q, n_d;
    logic [N_LED-1:0] on_q, on_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             entry, wrap;
    logic [N_LED-1:0] lit;
    logic             unused_track_ends;

    assign unused_track_ends = bus.track[0] ^ bus.track[N_LED+1];

    always_comb begin
        entry   = (bus.mode != mode_q);
        wrap    = (phase_q == PhaseMax);
        phase_d = (entry || wrap) ? '0 : phase_q + PhW'(1);

        pos_d = pos_q;
        if (entry) begin
            pos_d = '0;
        end else if (wrap) begin
            pos_d = (pos_q == PosMax) ? '0 : pos_q + PosW'(1);
        end

        st_d    = st_q;
        per_d   = per_q;
        n_d     = n_q;
        done_d  = 1'b0;
        per_inc = per_q + 4'd1;

        if (bus.mode != ModeBlink) begin
            st_d = StIdle;
        end else if (entry || st_q == StIdle) begin
            // blink_n is captured only here, so later changes wait for the next entry
            st_d  = StOn;
            per_d = '0;
            n_d   = bus.blink_n;
        end else begin
            case (st_q)
                StOn: if (wrap) st_d = StOff;
                StOff: begin
                    if (wrap) begin
                        if (n_q == 4'd0) begin
                            st_d = StOn;
                        end else if (per_inc == n_q) begin
                            st_d   = StDone;
                            per_d  = per_inc;
                            done_d = 1'b1;
                        end else begin
                            st_d  = StOn;
                            per_d = per_inc;
                        end
                    end
                end
                default: st_d = StDone;
            endcase
        end

        busy_d = ((st_d == StOn) || (st_d == StOff)) && (n_d != 4'd0);

        on_d = '0;
        case (bus.mode)
            ModeScore: on_d = bus.score;
            ModeServe: begin
                if (bus.right) on_d[N_LED-1] = 1'b1;
                else           on_d[0]       = 1'b1;
            end
            ModeTrack: on_d = bus.track[N_LED:1];
            ModeBlink: on_d = {N_LED{st_d == StOn}};
            ModeChase: on_d[pos_d] = 1'b1;
            default:   on_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= StIdle;
            mode_q  <= ModeOff;
            phase_q <= '0;
            pos_q   <= '0;
            per_q   <= '0;
            n_q     <= '0;
            on_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            mode_q  <= bus.mode;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            per_q   <= per_d;
            n_q     <= n_d;
            on_q    <= on_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic                pwm_gate;

    always_ff @(posedge clk) begin
        if (rst) pwm_cnt_q <= '0;
        else     pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end

    // Full-scale brightness is a steady on, not a 15/16 duty
    assign pwm_gate = (bus.bright == '1) || (pwm_cnt_q < bus.bright);
    assign lit      = on_q & {N_LED{pwm_gate}};
`else
    logic unused_bright;
    assign unused_bright = ^bus.bright;
    assign lit           = on_q;
`endif

    always_comb begin
        bus.led = '1;
        for (int i = 0; i < int'(N_LED); i++) begin
            bus.led[i] = ~lit[N_LED-1-i];
        end
    end

    assign bus.busy       = busy_q;
    assign bus.blink_done = done_q;
endmodule

// File: tb/tb_led_panel_ctrl.sv
// Self-checking bench for led_panel_ctrl: vector table, hand sequences, and a randomized run
// against a cycle-count reference model. PWM checks are compiled in when LED_PWM_EN is defined.
module tb_led_panel_ctrl;
    localparam int unsigned N  = 4;
    localparam int unsigned BC = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    led_panel_if #(.N_LED(N), .PWM_BITS(4)) bus ();

    led_panel_ctrl #(.N_LED(N), .BLINK_CYC(BC), .PWM_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] mode;
        logic [3:0] score;
        logic       right;
        logic [5:0] track;
        logic [3:0] blink_n;
        logic [3:0] exp_led;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    vec_t vecs[$];

    // Reference model state: last sampled mode, edges since entry, latched blink count
    logic [2:0] m_mode;
    int         m_k;
    int         m_n;
    logic [3:0] e_on;
    logic       e_busy;
    logic       e_done;

    function automatic logic [3:0] to_led(input logic [3:0] on);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = ~on[3-i];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        int len;
        @(posedge clk);
        e_busy = 1'b0;
        e_done = 1'b0;
        e_on   = 4'b0;
        if (rst) begin
            m_mode = 3'd0;
            m_k    = 0;
            m_n    = 0;
        end else begin
            if (bus.mode != m_mode) begin
                m_k = 0;
                m_n = int'(bus.blink_n);
            end else begin
                m_k++;
            end
            m_mode = bus.mode;
            case (bus.mode)
                3'd1: e_on = bus.score;
                3'd2: e_on = bus.right ? 4'b1000 : 4'b0001;
                3'd3: e_on = bus.track[4:1];
                3'd4: begin
                    len = 2 * m_n * int'(BC);
                    if (m_n != 0 && m_k >= len) begin
                        e_done = (m_k == len);
                    end else begin
                        e_on   = ((m_k / int'(BC)) % 2 == 0) ? 4'hF : 4'h0;
                        e_busy = (m_n != 0);
                    end
                end
                3'd5: e_on = 4'b0001 << ((m_k / int'(BC)) % int'(N));
                default: e_on = 4'b0;
            endcase
        end
        #1;
        if (bus.bright == 4'hF) check("model_led", 32'(bus.led), 32'(to_led(e_on)));
        check("model_busy", 32'(bus.busy), 32'(e_busy));
        check("model_done", 32'(bus.blink_done), 32'(e_done));
    endtask

    task automatic add(input logic r, input logic [2:0] m, input logic [3:0] s, input logic rt,
                       input logic [5:0] t, input logic [3:0] bn, input logic [3:0] el,
                       input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.mode = m; v.score = s; v.right = rt; v.track = t; v.blink_n = bn;
        v.exp_led = el; v.exp_busy = eb; v.exp_done = ed;
        vecs.push_back(v);
    endtask

    int pwm_low;

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        bus.mode    = 3'd0;
        bus.score   = 4'b0;
        bus.right   = 1'b0;
        bus.track   = 6'b0;
        bus.blink_n = 4'd0;
        bus.bright  = 4'hF;
        m_mode      = 3'd0;
        m_k         = 0;
        m_n         = 0;

        // rst, mode, score, right, track, blink_n, exp_led, exp_busy, exp_done
        add(1, 3'd1, 4'b1010, 0, 6'b0,      0, 4'b1111, 0, 0);
        add(1, 3'd1, 4'b1010, 0, 6'b0,      0, 4'b1111, 0, 0);
        add(1, 3'd1, 4'b1010, 0, 6'b0,      0, 4'b1111, 0, 0);
        add(0, 3'd1, 4'b1010, 0, 6'b0,      0, 4'b1010, 0, 0);
        add(0, 3'd1, 4'b0001, 0, 6'b0,      0, 4'b0111, 0, 0);
        add(0, 3'd1, 4'b1100, 0, 6'b0,      0, 4'b1100, 0, 0);
        add(0, 3'd2, 4'b1111, 1, 6'b0,      0, 4'b1110, 0, 0);
        add(0, 3'd2, 4'b1111, 0, 6'b0,      0, 4'b0111, 0, 0);
        add(0, 3'd3, 4'b0,    0, 6'b001100, 0, 4'b1001, 0, 0);
        add(0, 3'd3, 4'b0,    0, 6'b100001, 0, 4'b1111, 0, 0);
        add(0, 3'd3, 4'b0,    0, 6'b000010, 0, 4'b0111, 0, 0);
        add(0, 3'd0, 4'b1111, 1, 6'b111111, 0, 4'b1111, 0, 0);
        add(0, 3'd6, 4'b1111, 1, 6'b111111, 0, 4'b1111, 0, 0);
        add(0, 3'd7, 4'b1111, 1, 6'b111111, 0, 4'b1111, 0, 0);
        // blink forever; a late blink_n change must not start a counted run
        add(0, 3'd4, 4'b0,    0, 6'b0,      0, 4'b0000, 0, 0);
        add(0, 3'd4, 4'b0,    0, 6'b0,      1, 4'b0000, 0, 0);
        add(0, 3'd4, 4'b0,    0, 6'b0,      1, 4'b0000, 0, 0);
        add(0, 3'd4, 4'b0,    0, 6'b0,      1, 4'b0000, 0, 0);
        add(0, 3'd4, 4'b0,    0, 6'b0,      1, 4'b1111, 0, 0);

        foreach (vecs[i]) begin
            rst         = vecs[i].rst;
            bus.mode    = vecs[i].mode;
            bus.score   = vecs[i].score;
            bus.right   = vecs[i].right;
            bus.track   = vecs[i].track;
            bus.blink_n = vecs[i].blink_n;
            tick();
            check($sformatf("vec%0d_led", i), 32'(bus.led), 32'(vecs[i].exp_led));
            check($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_done", i), 32'(bus.blink_done), 32'(vecs[i].exp_done));
        end

        // Counted blink of two periods, then done pulse and dark panel
        bus.mode = 3'd1;
        tick();
        bus.mode    = 3'd4;
        bus.blink_n = 4'd2;
        for (int i = 0; i < 16; i++) begin
            tick();
            check("blink2_led", 32'(bus.led), 32'(((i / 4) % 2 == 0) ? 4'b0000 : 4'b1111));
            check("blink2_busy", 32'(bus.busy), 32'd1);
            check("blink2_nodone", 32'(bus.blink_done), 32'd0);
        end
        tick();
        check("blink2_done", 32'(bus.blink_done), 32'd1);
        check("blink2_busy_fall", 32'(bus.busy), 32'd0);
        check("blink2_dark", 32'(bus.led), 32'hF);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("blink2_after_done", 32'(bus.blink_done), 32'd0);
            check("blink2_after_led", 32'(bus.led), 32'hF);
        end

        // Abandon a counted blink by switching to TRACK
        bus.mode    = 3'd4;
        bus.blink_n = 4'd3;
        for (int i = 0; i < 6; i++) tick();
        bus.mode  = 3'd3;
        bus.track = 6'b001100;
        tick();
        check("abandon_led", 32'(bus.led), 32'b1001);
        check("abandon_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abandon_nodone", 32'(bus.blink_done), 32'd0);
        end

        // Chase visits 0,1,2,3,0 in BC-cycle steps
        bus.mode = 3'd5;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("chase_led", 32'(bus.led), 32'(to_led(4'b0001 << ((i / 4) % 4))));
        end

        // Reset mid-blink, then a fresh entry on release
        bus.mode    = 3'd4;
        bus.blink_n = 4'd1;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_led", 32'(bus.led), 32'hF);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        tick();
        check("rerun_led", 32'(bus.led), 32'h0);
        check("rerun_busy", 32'(bus.busy), 32'd1);

        // Randomized segments against the reference model
        for (int seg = 0; seg < 150; seg++) begin
            int seg_len;
            seg_len     = int'($urandom_range(1, 40));
            bus.mode    = 3'($urandom_range(0, 7));
            bus.blink_n = 4'($urandom_range(0, 3));
            for (int c = 0; c < seg_len; c++) begin
                bus.score = 4'($urandom);
                bus.right = 1'($urandom);
                bus.track = 6'($urandom);
                if ($urandom_range(0, 9) == 0) bus.blink_n = 4'($urandom_range(0, 3));
                rst = ($urandom_range(0, 99) == 0);
                tick();
            end
        end
        rst = 1'b0;

`ifdef LED_PWM_EN
        bus.mode  = 3'd1;
        bus.score = 4'hF;
        bus.bright = 4'd4;
        tick();
        pwm_low = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.led == 4'b0000) pwm_low++;
        end
        check("pwm_bright4", 32'(pwm_low), 32'd4);
        bus.bright = 4'd15;
        pwm_low = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.led == 4'b0000) pwm_low++;
        end
        check("pwm_bright15", 32'(pwm_low), 32'd16);
        bus.bright = 4'd0;
        pwm_low = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (bus.led == 4'b0000) pwm_low++;
        end
        check("pwm_bright0", 32'(pwm_low), 32'd0);
        bus.bright = 4'hF;
`else
        pwm_low = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
